// File: rtl/lat_tester_ctrl_if.sv
// Bundle of the controller's measurement-side signals: requests and sensing
// inputs from the host/video side, status and result outputs back to them.
interface lat_tester_ctrl_if #(
  parameter int CNT_WIDTH = 24
);

  logic                 start;
  logic                 vsync_in;
  logic                 sensor_in;
  logic                 lt_active;
  logic                 busy;
  logic [CNT_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 timeout;

  // Host/environment side: drives the request, VSYNC and photodiode level
  modport master (
    output start, vsync_in, sensor_in,
    input  lt_active, busy, result, result_valid, timeout
  );

  // Controller side
  modport slave (
    input  start, vsync_in, sensor_in,
    output lt_active, busy, result, result_valid, timeout
  );

endinterface

// File: rtl/lat_tester_ctrl.sv
// Display latency measurement controller. Waits for a VSYNC falling edge,
// raises lt_active so the video generator draws the test patch, then counts
// pixel-clock cycles until the filtered photodiode reports bright.
module lat_tester_ctrl #(
  parameter int                   CNT_WIDTH   = 24,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT     = 24'd2700000,
  parameter int                   SENSOR_FILT = 8
) (
  input  logic                 clk27,
  input  logic                 reset_n,
  lat_tester_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  localparam logic [3:0]           FILT_LAST  = 4'(SENSOR_FILT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = TIMEOUT - 1'b1;

  state_t               state_q;
  logic                 s1_q;
  logic                 s2_q;
  logic                 sensorFilt_q;
  logic [3:0]           filtCnt_q;
  logic                 vs_q;
  logic                 vsFall;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ltActive_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] result_q;
  logic                 resultValid_q;
  logic                 timeout_q;

  // VSYNC is active-low, so the start of a frame is its falling edge
  assign vsFall = vs_q & ~bus.vsync_in;

  // Synchronize the photodiode, debounce it, and keep a one-cycle VSYNC history
  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      sensorFilt_q <= 1'b0;
      filtCnt_q    <= '0;
      vs_q         <= 1'b1;
    end else begin
      s1_q <= bus.sensor_in;
      s2_q <= s1_q;
      vs_q <= bus.vsync_in;
      if (s2_q == sensorFilt_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FILT_LAST) begin
        sensorFilt_q <= s2_q;
        filtCnt_q    <= '0;
      end else begin
        filtCnt_q <= filtCnt_q + 4'd1;
      end
    end
  end

  // Measurement sequencer with registered status and result outputs
  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ltActive_q    <= 1'b0;
      busy_q        <= 1'b0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ltActive_q <= 1'b0;
          // A bright screen would fake an instant detection, so refuse to arm
          if (bus.start && !sensorFilt_q) begin
            state_q       <= ARM;
            busy_q        <= 1'b1;
            resultValid_q <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        ARM: begin
          if (vsFall) begin
            state_q    <= MEASURE;
            cnt_q      <= '0;
            ltActive_q <= 1'b1;
          end
        end
        MEASURE: begin
          cnt_q <= cnt_q + 1'b1;
          if (sensorFilt_q) begin
            result_q      <= cnt_q;
            resultValid_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            result_q  <= TIMEOUT;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          ltActive_q <= 1'b0;
          busy_q     <= 1'b0;
          // Only a released request on a dark screen re-enables the next test
          if (!bus.start && !sensorFilt_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.lt_active    = ltActive_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = resultValid_q;
  assign bus.timeout      = timeout_q;

endmodule
